baby_store_loader: RTL and testbench
====================================

// Module: baby_store_loader
// PURPOSE
// - 32 x 32-bit main store for the Baby CPU, plus a serial program loader.
// - Sits directly downstream of the CPU RAM port and serves its address, data and rw_en signals.
// - The loader fills the store bit-serially and holds the CPU in reset (cpu_hold_o) while loading.
// - After the last word is written, the loader releases the CPU automatically.
// PARAMETERS
// - WORDS   32  store depth in words
// - WIDTH   32  word width in bits
// - ADDR_W  5   address width (clog2 WORDS)
// PORTS
// - globalClock     in   1       single clock, all state on rising edge
// - reset_i         in   1       asynchronous, active-high reset
// - cpu_tick_i      in   1       CPU clock-enable tick; CPU writes qualify on it
// - ram_addr_i      in   ADDR_W  CPU store address
// - ram_data_i      in   WIDTH   CPU write data
// - ram_rw_en_i     in   1       1 = write, 0 = read
// - ram_data_o      out  WIDTH   read data = mem[ram_addr_i]
// - load_start_i    in   1       pulse: begin or restart a load at word 0
// - load_valid_i    in   1       load_bit_i is valid this cycle
// - load_bit_i      in   1       serial data, LSB of each word first, word 0 first
// - load_busy_o     out  1       1 while in LOAD
// - run_i           in   1       pulse: leave HOLD and run the CPU
// - cpu_hold_o      out  1       drives the CPU reset_i; 1 = CPU held
// - dump_req_i      in   1       (BABY_STORE_DUMP_EN) pulse: stream out the store
// - dump_valid_o    out  1       (BABY_STORE_DUMP_EN) dump_bit_o is valid
// - dump_bit_o      out  1       (BABY_STORE_DUMP_EN) serial data, same order as load
// BEHAVIOUR
// - Reset values: state=HOLD, cpu_hold_o=1, load_busy_o=0, dump_valid_o=0, dump_bit_o=0, counters=0.
// - Store contents are NOT cleared by reset.
// - Read path: ram_data_o = mem[ram_addr_i] combinationally, in every state, with zero latency.
// - CPU write: mem[ram_addr_i] <= ram_data_i at the edge where state=RUN && ram_rw_en_i && cpu_tick_i.
//   CPU writes are ignored in every other state.
// - FSM (states HOLD, LOAD, RUN, DUMP):
//   - HOLD: load_start_i -> LOAD; else dump_req_i -> DUMP; else run_i -> RUN.
//   - RUN: load_start_i -> LOAD; else dump_req_i -> DUMP. cpu_hold_o=0 only in RUN.
//   - LOAD: each load_valid_i shifts load_bit_i into bit position bit_cnt of a 32-bit word register.
//     - On bit_cnt==31, write the assembled word to mem[word_cnt] and increment word_cnt.
//     - When word 31 is written: -> RUN; cpu_hold_o falls on the next edge.
//     - load_start_i in LOAD: restart at word 0, bit 0, and discard the partial word.
//       load_start_i outranks load_valid_i in the same cycle.
//     - Gaps in load_valid_i are allowed; no timeout.
//   - Priority: load_start_i > dump_req_i > run_i.
// - Counters: bit_cnt and word_cnt are 5 bits and wrap 31->0. They are cleared on entry to LOAD/DUMP.
// - Reset asserted mid-LOAD: return to HOLD. Words already written remain; the partial word is lost.
// CONFIGURATION
// - BABY_STORE_DUMP_EN defined: the DUMP state exists.
//   - One bit per cycle: mem[word_cnt][bit_cnt], with dump_valid_o=1, for 1024 cycles.
//   - The first bit appears the cycle after DUMP is entered.
//   - Then -> HOLD. load_start_i aborts the dump -> LOAD. cpu_hold_o=1 throughout.
// - BABY_STORE_DUMP_EN undefined: the dump ports are absent and dump_req_i is not decoded.
// STRUCTURE
// - Package baby_pkg holds: the state enum (HOLD, LOAD, RUN, DUMP), WORD_W=32, ADDR_W=5, WORDS=32, and RW_WRITE=1'b1.
// - Sub-module baby_store_mem: async-read, sync-write register array, with 1 read port and 1 write port.
//   The write mux between loader and CPU lives in baby_store_loader.
// TESTING
// - Reset: cpu_hold_o=1, load_busy_o=0, state HOLD. A CPU write with rw_en=1 and tick=1 leaves mem unchanged.
// - Load: start, then 1024 valid bits with word k = 32'hA5000000|k.
//   - Expect: mem[k] matches for all k; cpu_hold_o=0 one cycle after the last bit.
// - Gapped load plus restart:
//   - Send 40 bits (words with valid gaps), then load_start_i.
//   - Reload word 0 = 32'h1, then 1023 zero bits.
//   - Expect: mem[0]=1; the partial word is discarded.
// - CPU port in RUN:
//   - Write 32'hDEADBEEF @ addr 7 with tick=0: no change.
//   - Repeat with tick=1: ram_data_o=32'hDEADBEEF with zero-cycle latency.
// - Simultaneous events: load_start_i+dump_req_i+run_i in HOLD -> LOAD. Reset mid-load (after word 3) -> HOLD, mem[0..2] kept.
// - DUMP_EN: after loading a known image, dump_req_i -> 1024 bits match the image, then HOLD with cpu_hold_o=1.

Source files
------------

// File: rtl/baby_pkg.sv
// Shared constants and the loader FSM state type for the Baby main store.
// Optional dump streaming is enabled with the BABY_STORE_DUMP_EN macro.
package baby_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 5;
  localparam int WORDS  = 32;
  localparam int BIT_W  = 5;

  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DUMP = 2'd3
  } state_t;

endpackage

// File: rtl/baby_store_mem.sv
// 32 x 32-bit register array: async read, sync write, no reset on contents.
// BABY_STORE_DUMP_EN adds a second read port used only by the dump streamer.
module baby_store_mem
  import baby_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
`ifdef BABY_STORE_DUMP_EN
  ,
  input  logic [ADDR_W-1:0] daddr,
  output logic [WORD_W-1:0] ddata
`endif
);

  logic [WORD_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

`ifdef BABY_STORE_DUMP_EN
  assign ddata = mem[daddr];
`endif

endmodule

// File: rtl/baby_store_loader.sv
// Baby main store with bit-serial loader that holds the CPU until loaded.
// Define BABY_STORE_DUMP_EN to add the serial dump state and ports.
module baby_store_loader
  import baby_pkg::*;
(
  input  logic              globalClock,
  input  logic              reset_i,
  input  logic              cpu_tick_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [WORD_W-1:0] ram_data_i,
  input  logic              ram_rw_en_i,
  output logic [WORD_W-1:0] ram_data_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic              load_bit_i,
  output logic              load_busy_o,
  input  logic              run_i,
  output logic              cpu_hold_o
`ifdef BABY_STORE_DUMP_EN
  ,
  input  logic              dump_req_i,
  output logic              dump_valid_o,
  output logic              dump_bit_o
`endif
);

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] word_cnt;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;

  logic              last_bit;
  logic              last_word;
  logic              ld_we;
  logic              cpu_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic              dump_go;

  assign last_bit  = (bit_cnt == BIT_W'(WORD_W - 1));
  assign last_word = (word_cnt == ADDR_W'(WORDS - 1));

  // A restart in the same cycle as a final bit wins, so no write happens.
  assign ld_we = (state == LOAD) && !load_start_i
               && load_valid_i && last_bit;

  assign cpu_we = (state == RUN) && cpu_tick_i
                && (ram_rw_en_i == RW_WRITE);

  always_comb begin
    word_d          = word_q;
    word_d[bit_cnt] = load_bit_i;
  end

  assign mem_we    = ld_we | cpu_we;
  assign mem_waddr = ld_we ? word_cnt : ram_addr_i;
  assign mem_wdata = ld_we ? word_d : ram_data_i;

`ifdef BABY_STORE_DUMP_EN
  logic [WORD_W-1:0] dump_word;
  assign dump_go = dump_req_i;
`else
  assign dump_go = 1'b0;
`endif

  baby_store_mem u_mem (
    .clk   (globalClock),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (ram_addr_i),
    .rdata (ram_data_o)
`ifdef BABY_STORE_DUMP_EN
    ,
    .daddr (word_cnt),
    .ddata (dump_word)
`endif
  );

  always_ff @(posedge globalClock or posedge reset_i) begin
    if (reset_i) begin
      state    <= HOLD;
      bit_cnt  <= '0;
      word_cnt <= '0;
      word_q   <= '0;
    end else begin
      unique case (state)
        HOLD, RUN: begin
          if (load_start_i) begin
            state    <= LOAD;
            bit_cnt  <= '0;
            word_cnt <= '0;
            word_q   <= '0;
          end else if (dump_go) begin
            state    <= DUMP;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end else if (state == HOLD && run_i) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (load_start_i) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            word_q   <= '0;
          end else if (load_valid_i) begin
            word_q  <= word_d;
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (last_bit) begin
              word_cnt <= word_cnt + ADDR_W'(1);
              if (last_word) begin
                state <= RUN;
              end
            end
          end
        end
        DUMP: begin
          if (load_start_i) begin
            state    <= LOAD;
            bit_cnt  <= '0;
            word_cnt <= '0;
            word_q   <= '0;
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (last_bit) begin
              word_cnt <= word_cnt + ADDR_W'(1);
              if (last_word) begin
                state <= HOLD;
              end
            end
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

`ifdef BABY_STORE_DUMP_EN
  // Bit for the current counters is registered, so it shows one cycle later.
  always_ff @(posedge globalClock or posedge reset_i) begin
    if (reset_i) begin
      dump_valid_o <= 1'b0;
      dump_bit_o   <= 1'b0;
    end else if (state == DUMP && !load_start_i) begin
      dump_valid_o <= 1'b1;
      dump_bit_o   <= dump_word[bit_cnt];
    end else begin
      dump_valid_o <= 1'b0;
      dump_bit_o   <= 1'b0;
    end
  end
`endif

  assign load_busy_o = (state == LOAD);
  assign cpu_hold_o  = (state != RUN);

endmodule

// File: tb/tb_baby_store_loader.sv
// Directed-plus-random bench for baby_store_loader against an array model.
// Dump checks are compiled in when BABY_STORE_DUMP_EN is defined.
module tb_baby_store_loader;
  import baby_pkg::*;

  logic              globalClock = 1'b0;
  logic              reset_i     = 1'b1;
  logic              cpu_tick_i  = 1'b0;
  logic [ADDR_W-1:0] ram_addr_i  = '0;
  logic [WORD_W-1:0] ram_data_i  = '0;
  logic              ram_rw_en_i = 1'b0;
  logic [WORD_W-1:0] ram_data_o;
  logic              load_start_i = 1'b0;
  logic              load_valid_i = 1'b0;
  logic              load_bit_i   = 1'b0;
  logic              load_busy_o;
  logic              run_i = 1'b0;
  logic              cpu_hold_o;
`ifdef BABY_STORE_DUMP_EN
  logic              dump_req_i = 1'b0;
  logic              dump_valid_o;
  logic              dump_bit_o;
`endif

  baby_store_loader dut (
    .globalClock  (globalClock),
    .reset_i      (reset_i),
    .cpu_tick_i   (cpu_tick_i),
    .ram_addr_i   (ram_addr_i),
    .ram_data_i   (ram_data_i),
    .ram_rw_en_i  (ram_rw_en_i),
    .ram_data_o   (ram_data_o),
    .load_start_i (load_start_i),
    .load_valid_i (load_valid_i),
    .load_bit_i   (load_bit_i),
    .load_busy_o  (load_busy_o),
    .run_i        (run_i),
    .cpu_hold_o   (cpu_hold_o)
`ifdef BABY_STORE_DUMP_EN
    ,
    .dump_req_i   (dump_req_i),
    .dump_valid_o (dump_valid_o),
    .dump_bit_o   (dump_bit_o)
`endif
  );

  always #5 globalClock = ~globalClock;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] model [32];
  logic [31:0] img   [32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge globalClock);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) step();
    load_valid_i = 1'b1;
    load_bit_i   = b;
    step();
    load_valid_i = 1'b0;
    load_bit_i   = 1'b0;
  endtask

  task automatic pulse_start();
    load_start_i = 1'b1;
    step();
    load_start_i = 1'b0;
  endtask

  // Streams img LSB-first, word 0 first; the loader must already be in LOAD.
  task automatic send_image(input bit gaps);
    for (int w = 0; w < 32; w++) begin
      for (int b = 0; b < 32; b++) begin
        if (w == 31 && b == 31)
          chk("hold_before_last_bit", 32'(cpu_hold_o), 32'd1);
        send_bit(img[w][b], gaps);
      end
      model[w] = img[w];
    end
    chk("hold_after_last_bit", 32'(cpu_hold_o), 32'd0);
    chk("busy_after_last_bit", 32'(load_busy_o), 32'd0);
  endtask

  task automatic check_store(input string tag);
    for (int a = 0; a < 32; a++) begin
      ram_addr_i = ADDR_W'(a);
      #1;
      chk($sformatf("%s[%0d]", tag, a), ram_data_o, model[a]);
    end
  endtask

  initial begin
    logic [31:0] r0;
    logic [31:0] part;
    logic [4:0]  a;
    logic [31:0] d;
    logic        t;

    // Reset state
    #12;
    chk("rst_hold", 32'(cpu_hold_o), 32'd1);
    chk("rst_busy", 32'(load_busy_o), 32'd0);
`ifdef BABY_STORE_DUMP_EN
    chk("rst_dump_valid", 32'(dump_valid_o), 32'd0);
    chk("rst_dump_bit", 32'(dump_bit_o), 32'd0);
`endif
    reset_i = 1'b0;
    step();
    chk("hold_idle", 32'(cpu_hold_o), 32'd1);

    // Full load of the A5 image with random valid gaps
    for (int k = 0; k < 32; k++) img[k] = 32'hA500_0000 | 32'(k);
    pulse_start();
    chk("busy_after_start", 32'(load_busy_o), 32'd1);
    chk("hold_in_load", 32'(cpu_hold_o), 32'd1);
    send_image(1'b1);
    check_store("a5_img");

    // CPU write in RUN: tick gates it, read is zero latency
    ram_addr_i  = 5'd7;
    ram_data_i  = 32'hDEAD_BEEF;
    ram_rw_en_i = 1'b1;
    cpu_tick_i  = 1'b0;
    step();
    chk("wr_no_tick", ram_data_o, model[7]);
    cpu_tick_i = 1'b1;
    step();
    chk("wr_tick", ram_data_o, 32'hDEAD_BEEF);
    model[7]    = 32'hDEAD_BEEF;
    ram_rw_en_i = 1'b0;
    cpu_tick_i  = 1'b0;

    // Random CPU traffic in RUN
    for (int i = 0; i < 24; i++) begin
      a = 5'($urandom);
      d = $urandom;
      t = 1'($urandom);
      ram_addr_i  = a;
      ram_data_i  = d;
      ram_rw_en_i = 1'($urandom);
      cpu_tick_i  = t;
      if (t && ram_rw_en_i) model[a] = d;
      step();
    end
    ram_rw_en_i = 1'b0;
    cpu_tick_i  = 1'b0;
    check_store("cpu_rand");

    // Gapped partial load, then restart discards the partial word
    pulse_start();
    r0   = $urandom;
    part = $urandom;
    for (int b = 0; b < 40; b++)
      send_bit(b < 32 ? r0[b] : part[b-32], 1'b1);
    model[0]   = r0;
    ram_addr_i = 5'd0;
    #1;
    chk("partial_w0", ram_data_o, r0);
    chk("busy_partial", 32'(load_busy_o), 32'd1);
    pulse_start();
    chk("busy_restart", 32'(load_busy_o), 32'd1);
    img[0] = 32'h1;
    for (int k = 1; k < 32; k++) img[k] = 32'h0;
    send_image(1'b1);
    check_store("restart");

    // Simultaneous requests from HOLD, then reset mid-load
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("hold_reset2", 32'(cpu_hold_o), 32'd1);
    load_start_i = 1'b1;
    run_i        = 1'b1;
`ifdef BABY_STORE_DUMP_EN
    dump_req_i   = 1'b1;
`endif
    step();
    load_start_i = 1'b0;
    run_i        = 1'b0;
`ifdef BABY_STORE_DUMP_EN
    dump_req_i   = 1'b0;
`endif
    chk("prio_busy", 32'(load_busy_o), 32'd1);
    chk("prio_hold", 32'(cpu_hold_o), 32'd1);
    for (int k = 0; k < 4; k++) img[k] = $urandom;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 32; b++)
        if (w < 3 || b < 5) send_bit(img[w][b], 1'b1);
    for (int k = 0; k < 3; k++) model[k] = img[k];
    reset_i = 1'b1;
    #1;
    chk("midload_busy", 32'(load_busy_o), 32'd0);
    chk("midload_hold", 32'(cpu_hold_o), 32'd1);
    step();
    reset_i = 1'b0;
    check_store("midload");

    // CPU write ignored in HOLD, then run releases the CPU
    ram_addr_i  = 5'd5;
    ram_data_i  = ~model[5];
    ram_rw_en_i = 1'b1;
    cpu_tick_i  = 1'b1;
    step();
    chk("hold_wr_ignored", ram_data_o, model[5]);
    ram_rw_en_i = 1'b0;
    cpu_tick_i  = 1'b0;
    run_i = 1'b1;
    step();
    run_i = 1'b0;
    chk("run_hold", 32'(cpu_hold_o), 32'd0);

`ifdef BABY_STORE_DUMP_EN
    begin
      logic [31:0] dw [32];
      int          got;
      bit          hold_bad;
      for (int k = 0; k < 32; k++) img[k] = $urandom;
      pulse_start();
      send_image(1'b0);
      dump_req_i = 1'b1;
      step();
      dump_req_i = 1'b0;
      chk("dump_hold_entry", 32'(cpu_hold_o), 32'd1);
      got      = 0;
      hold_bad = 1'b0;
      for (int k = 0; k < 32; k++) dw[k] = '0;
      for (int c = 0; c < 1100; c++) begin
        step();
        if (cpu_hold_o !== 1'b1) hold_bad = 1'b1;
        if (dump_valid_o === 1'b1) begin
          if (got < 1024) dw[got/32][got%32] = dump_bit_o;
          got++;
        end else if (got > 0) begin
          break;
        end
      end
      chk("dump_count", 32'(got), 32'd1024);
      chk("dump_hold_throughout", 32'(hold_bad), 32'd0);
      for (int k = 0; k < 32; k++)
        chk($sformatf("dump_w[%0d]", k), dw[k], model[k]);
      chk("dump_end_valid", 32'(dump_valid_o), 32'd0);
      chk("dump_end_hold", 32'(cpu_hold_o), 32'd1);
      chk("dump_end_busy", 32'(load_busy_o), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
